// File: rtl/key_event_scheduler_pkg.sv
// Shared definitions for the key event scheduler: event encodings and
// width helpers used to size counters and key indices.
package key_event_scheduler_pkg;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    // Counter width able to hold every value 0..value without wrapping.
    function automatic int cnt_width(input int value);
        return $clog2(value) + 1;
    endfunction

    // Width of a key index; at least one bit even for a single key.
    function automatic int idx_width(input int count);
        if (count > 1) begin
            return $clog2(count);
        end else begin
            return 1;
        end
    endfunction

    function automatic int max_of(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/key_event_scheduler_debounce.sv
// One key lane: two-flop synchroniser, integrating debounce, hold/repeat
// timer and a single-entry pending event slot.
module key_debounce_unit
    import key_event_scheduler_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_raw,
    input  logic       tick,
    input  logic       take,
    output logic       state,
    output logic       pend_valid,
    output logic [1:0] pend_type,
    output logic       drop
);

    localparam int SW = cnt_width(STABLE_TICKS);
    localparam int HW = cnt_width(max_of(HOLD_TICKS, REPEAT_TICKS));
    localparam logic [SW-1:0] STABLE_LIM = SW'(STABLE_TICKS);
    localparam logic [HW-1:0] HOLD_LIM   = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] REPEAT_LIM = HW'(REPEAT_TICKS);

    logic [1:0]    sync_q,  sync_d;
    logic          state_q, state_d;
    logic [SW-1:0] scnt_q,  scnt_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic          rep_q,   rep_d;
    logic          pv_q,    pv_d;
    logic [1:0]    pt_q,    pt_d;
    logic          post_s;
    logic [1:0]    post_type_s;
    logic [HW-1:0] hold_lim_s;

    assign state      = state_q;
    assign pend_valid = pv_q;
    assign pend_type  = pt_q;

    // Next-state for sync, debounce, hold/repeat timer and the pending slot.
    always_comb begin
        sync_d      = {sync_q[0], key_raw};
        state_d     = state_q;
        scnt_d      = scnt_q;
        hold_d      = hold_q;
        rep_d       = rep_q;
        pv_d        = pv_q;
        pt_d        = pt_q;
        post_s      = 1'b0;
        post_type_s = EV_PRESS;
        drop        = 1'b0;
        hold_lim_s  = rep_q ? REPEAT_LIM : HOLD_LIM;

        if (tick) begin
            if (sync_q[1] == state_q) begin
                scnt_d = '0;
            end else if (scnt_q + 1'b1 == STABLE_LIM) begin
                state_d     = sync_q[1];
                scnt_d      = '0;
                post_s      = 1'b1;
                post_type_s = sync_q[1] ? EV_PRESS : EV_RELEASE;
            end else begin
                scnt_d = scnt_q + 1'b1;
            end

            // A release tick clears the timer before it can fire a repeat.
            if (!state_q || post_s) begin
                hold_d = '0;
                rep_d  = 1'b0;
            end else if (hold_q + 1'b1 == hold_lim_s) begin
                hold_d      = '0;
                rep_d       = 1'b1;
                post_s      = 1'b1;
                post_type_s = EV_REPEAT;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            scnt_d = scnt_q;
        end

        // A post coinciding with the arbiter taking the slot refills it silently.
        if (post_s) begin
            pv_d = 1'b1;
            pt_d = post_type_s;
            drop = pv_q && !take;
        end else if (take) begin
            pv_d = 1'b0;
        end else begin
            pv_d = pv_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= 1'b0;
            scnt_q  <= '0;
            hold_q  <= '0;
            rep_q   <= 1'b0;
            pv_q    <= 1'b0;
            pt_q    <= 2'b00;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            pv_q    <= pv_d;
            pt_q    <= pt_d;
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Multi-key front end: sample-tick prescaler, per-key debounce lanes and a
// round-robin arbiter feeding one registered valid/ready event stream.
module key_event_scheduler
    import key_event_scheduler_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 25
) (
    input  logic                            iClock,
    input  logic                            iResetN,
    input  logic [NUM_KEYS-1:0]             iKey,
    output logic [NUM_KEYS-1:0]             oKeyState,
    output logic                            oEventValid,
    input  logic                            iEventReady,
    output logic [idx_width(NUM_KEYS)-1:0]  oEventKey,
    output logic [1:0]                      oEventType,
    output logic                            oDrop
);

    localparam int KW   = idx_width(NUM_KEYS);
    localparam int SUMW = KW + 1;
    localparam int PW   = cnt_width(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [KW-1:0]   KEY_LAST   = KW'(NUM_KEYS - 1);
    localparam logic [SUMW-1:0] KEY_COUNT  = SUMW'(NUM_KEYS);

    logic [PW-1:0]              presc_q, presc_d;
    logic                       tick_s;
    logic                       valid_q, valid_d;
    logic [KW-1:0]              key_q,   key_d;
    logic [1:0]                 type_q,  type_d;
    logic [KW-1:0]              ptr_q,   ptr_d;
    logic                       drop_q,  drop_d;
    logic [NUM_KEYS-1:0]        key_state_s;
    logic [NUM_KEYS-1:0]        pend_valid_s;
    logic [NUM_KEYS-1:0][1:0]   pend_type_s;
    logic [NUM_KEYS-1:0]        drop_s;
    logic [NUM_KEYS-1:0]        take_s;
    logic                       found_s;
    logic [KW-1:0]              sel_s;
    logic [KW-1:0]              idx_s;
    logic [SUMW-1:0]            sum_s;

    assign oKeyState   = key_state_s;
    assign oEventValid = valid_q;
    assign oEventKey   = key_q;
    assign oEventType  = type_q;
    assign oDrop       = drop_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce_unit #(
            .STABLE_TICKS (STABLE_TICKS),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_key (
            .clk        (iClock),
            .rst_n      (iResetN),
            .key_raw    (iKey[g]),
            .tick       (tick_s),
            .take       (take_s[g]),
            .state      (key_state_s[g]),
            .pend_valid (pend_valid_s[g]),
            .pend_type  (pend_type_s[g]),
            .drop       (drop_s[g])
        );
    end

    // Sample-tick prescaler: one-clock tick at the last count, then wrap.
    always_comb begin
        tick_s = (presc_q == PRESC_LAST);
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Round-robin search for the first pending key at or after the pointer.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            sum_s = {1'b0, ptr_q} + SUMW'(i);
            if (sum_s >= KEY_COUNT) begin
                sum_s = sum_s - KEY_COUNT;
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[KW-1:0];
            if (!found_s && pend_valid_s[idx_s]) begin
                found_s = 1'b1;
                sel_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Output register load and slot take; held while stalled.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        type_d  = type_q;
        ptr_d   = ptr_q;
        take_s  = '0;
        drop_d  = |drop_s;
        if (!valid_q || iEventReady) begin
            if (found_s) begin
                valid_d       = 1'b1;
                key_d         = sel_s;
                type_d        = pend_type_s[sel_s];
                take_s[sel_s] = 1'b1;
                ptr_d         = (sel_s == KEY_LAST) ? '0 : sel_s + 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Prescaler, arbiter and output registers.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            presc_q <= '0;
            valid_q <= 1'b0;
            key_q   <= '0;
            type_q  <= 2'b00;
            ptr_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            valid_q <= valid_d;
            key_q   <= key_d;
            type_q  <= type_d;
            ptr_q   <= ptr_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench for key_event_scheduler with a behavioural model.
module tb_key_event_scheduler;

    localparam int NK = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int HT = 8;
    localparam int RT = 4;

    logic          iClock = 1'b0;
    logic          iResetN = 1'b0;
    logic [NK-1:0] iKey = '0;
    logic          iEventReady = 1'b1;
    logic [NK-1:0] oKeyState;
    logic          oEventValid;
    logic [1:0]    oEventKey;
    logic [1:0]    oEventType;
    logic          oDrop;

    key_event_scheduler #(
        .NUM_KEYS(NK), .TICK_DIV(TD), .STABLE_TICKS(ST),
        .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut (
        .iClock(iClock), .iResetN(iResetN), .iKey(iKey),
        .oKeyState(oKeyState), .oEventValid(oEventValid),
        .iEventReady(iEventReady), .oEventKey(oEventKey),
        .oEventType(oEventType), .oDrop(oDrop)
    );

    always #5 iClock = ~iClock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural model state
    int m_s1[NK], m_s2[NK], m_state[NK], m_scnt[NK], m_hold[NK], m_rep[NK];
    int m_pv[NK], m_pt[NK];
    int m_presc, m_ptr, m_ov, m_okey, m_otype, m_drop;

    typedef struct { int key; int typ; int cyc; } ev_t;
    ev_t acc[$];

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_state[k] = 0; m_scnt[k] = 0;
            m_hold[k] = 0; m_rep[k] = 0; m_pv[k] = 0; m_pt[k] = 0;
        end
        m_presc = 0; m_ptr = 0; m_ov = 0; m_okey = 0; m_otype = 0; m_drop = 0;
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        int tick, taken, old_state, s;
        int post[NK];
        int ptype[NK];
        tick = (m_presc == TD - 1) ? 1 : 0;
        m_presc = tick ? 0 : m_presc + 1;
        for (int k = 0; k < NK; k++) begin
            post[k] = 0; ptype[k] = 0;
            if (tick) begin
                s = m_s2[k];
                old_state = m_state[k];
                if (s == old_state) m_scnt[k] = 0;
                else if (m_scnt[k] + 1 == ST) begin
                    m_state[k] = s; m_scnt[k] = 0; post[k] = 1; ptype[k] = s ? 1 : 2;
                end else m_scnt[k] = m_scnt[k] + 1;
                if (old_state == 0 || post[k]) begin
                    m_hold[k] = 0; m_rep[k] = 0;
                end else begin
                    m_hold[k] = m_hold[k] + 1;
                    if (m_hold[k] == (m_rep[k] ? RT : HT)) begin
                        m_hold[k] = 0; m_rep[k] = 1; post[k] = 1; ptype[k] = 3;
                    end
                end
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = int'(iKey[k]);
        end
        taken = -1;
        if (!m_ov || iEventReady) begin
            for (int i = 0; i < NK; i++) begin
                if (taken < 0 && m_pv[(m_ptr + i) % NK]) taken = (m_ptr + i) % NK;
            end
            if (taken >= 0) begin
                m_ov = 1; m_okey = taken; m_otype = m_pt[taken]; m_ptr = (taken + 1) % NK;
            end else m_ov = 0;
        end
        m_drop = 0;
        for (int k = 0; k < NK; k++) begin
            if (post[k]) begin
                if (m_pv[k] && taken != k) m_drop = 1;
                m_pv[k] = 1; m_pt[k] = ptype[k];
            end else if (taken == k) m_pv[k] = 0;
        end
    endtask

    function automatic logic [9:0] exp_vec();
        logic [NK-1:0] st;
        for (int k = 0; k < NK; k++) st[k] = m_state[k][0];
        return {st, m_ov[0], m_okey[1:0], m_otype[1:0], m_drop[0]};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {oKeyState, oEventValid, oEventKey, oEventType, oDrop};
    endfunction

    // One clock: log handshakes, step model, sample #1 after the edge.
    task automatic cycle();
        if (iResetN && oEventValid && iEventReady)
            acc.push_back('{int'(oEventKey), int'(oEventType), cyc});
        if (iResetN) model_step(); else model_reset();
        @(posedge iClock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        iResetN = 1'b0; iKey = '0; iEventReady = 1'b1;
        model_reset();
        repeat (3) cycle();
        checks++;
        if (obs_vec() !== 10'd0) begin
            errors++; $display("FAIL reset_values got=%b want=%b", obs_vec(), 10'd0);
        end
        iResetN = 1'b1;
    endtask

    task automatic test_clean_press();
        int start, p, r, rp;
        start = acc.size(); p = 0; r = 0; rp = 0;
        iKey[2] = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (n == 24) iKey[2] = 1'b0;
            cycle(); checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL clean_press cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
        end
        for (int i = start; i < acc.size(); i++) begin
            if (acc[i].key == 2 && acc[i].typ == 1) p++;
            if (acc[i].key == 2 && acc[i].typ == 2) r++;
            if (acc[i].typ == 3) rp++;
        end
        checks++;
        if (p != 1 || r != 1 || rp != 0 || acc.size() - start != 2) begin
            errors++; $display("FAIL clean_press_events got press=%0d rel=%0d rep=%0d total=%0d want 1/1/0/2",
                               p, r, rp, acc.size() - start);
        end
    endtask

    task automatic test_chatter();
        int start;
        start = acc.size();
        for (int n = 0; n < 60; n++) begin
            if (n < 40 && n % 4 == 0) iKey[0] = ~iKey[0];
            cycle(); checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL chatter cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (acc.size() != start || oKeyState !== 4'b0000) begin
            errors++; $display("FAIL chatter_quiet got events=%0d state=%b want 0/0000", acc.size() - start, oKeyState);
        end
    endtask

    // 22 ticks of raw hold keep the debounced level up 22 ticks: 21 timer
    // increments give repeats at 8, 12, 16 and 20 ticks after the press.
    task automatic test_hold_repeat();
        int start, p, r, rp, c_press;
        int c_rep[$];
        start = acc.size(); p = 0; r = 0; rp = 0; c_press = 0;
        iKey[1] = 1'b1;
        for (int n = 0; n < 128; n++) begin
            if (n == 88) iKey[1] = 1'b0;
            cycle(); checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL hold_repeat cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
        end
        for (int i = start; i < acc.size(); i++) begin
            if (acc[i].key == 1) begin
                case (acc[i].typ)
                    1: begin p++; c_press = acc[i].cyc; end
                    2: r++;
                    3: begin rp++; c_rep.push_back(acc[i].cyc); end
                    default: ;
                endcase
            end
        end
        checks++;
        if (p != 1 || r != 1 || rp != 4) begin
            errors++; $display("FAIL hold_repeat_count got press=%0d rel=%0d rep=%0d want 1/1/4", p, r, rp);
        end
        if (rp > 0) begin
            checks++;
            if (c_rep[0] - c_press != HT * TD) begin
                errors++; $display("FAIL first_repeat_gap got=%0d want=%0d", c_rep[0] - c_press, HT * TD);
            end
            for (int i = 1; i < c_rep.size(); i++) begin
                checks++;
                if (c_rep[i] - c_rep[i-1] != RT * TD) begin
                    errors++; $display("FAIL repeat_gap got=%0d want=%0d", c_rep[i] - c_rep[i-1], RT * TD);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int start, start2;
        iResetN = 1'b0; iKey = '0; iEventReady = 1'b1;
        repeat (2) cycle();
        iResetN = 1'b1;
        iEventReady = 1'b0; iKey = 4'b1111;
        start = acc.size();
        for (int n = 0; n < 72; n++) begin
            if (n == 20) iEventReady = 1'b1;
            if (n == 28) iKey = 4'b0000;
            cycle(); checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (acc.size() - start != 8) begin
            errors++; $display("FAIL b2b_count got=%0d want=8", acc.size() - start);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (acc[start+i].key != i % 4 || acc[start+i].typ != (i < 4 ? 1 : 2)) begin
                    errors++; $display("FAIL b2b_order idx=%0d got key=%0d type=%0d want key=%0d type=%0d",
                                       i, acc[start+i].key, acc[start+i].typ, i % 4, i < 4 ? 1 : 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc[start+i].cyc != acc[start].cyc + i) begin
                    errors++; $display("FAIL b2b_rate idx=%0d got cyc=%0d want=%0d", i, acc[start+i].cyc, acc[start].cyc + i);
                end
            end
        end
        start2 = acc.size();
        iKey = 4'b1001;
        for (int n = 0; n < 64; n++) begin
            if (n == 24) iKey = 4'b0000;
            cycle(); checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL wrap_pair cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (acc.size() - start2 < 2 || acc[start2].key != 0 || acc[start2+1].key != 3) begin
            errors++; $display("FAIL wrap_order got n=%0d first=%0d second=%0d want 0 then 3", acc.size() - start2,
                               acc.size() > start2 ? acc[start2].key : -1,
                               acc.size() > start2 + 1 ? acc[start2+1].key : -1);
        end
    endtask

    // 11 ticks held: one repeat lands in the empty slot, the release then
    // overwrites it, which must be the only drop.
    task automatic test_stall_overwrite();
        int start, drops;
        drops = 0;
        iEventReady = 1'b0; iKey[1] = 1'b1;
        for (int n = 0; n < 80; n++) begin
            if (n == 44) iKey[1] = 1'b0;
            cycle(); checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL stall cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
            if (oDrop === 1'b1) drops++;
            if (oEventValid === 1'b1) begin
                checks++;
                if (oEventKey !== 2'd1 || oEventType !== 2'b01) begin
                    errors++; $display("FAIL stall_hold got key=%0d type=%b want 1/01", oEventKey, oEventType);
                end
            end
        end
        checks++;
        if (drops != 1) begin
            errors++; $display("FAIL drop_count got=%0d want=1", drops);
        end
        iEventReady = 1'b1;
        start = acc.size();
        for (int n = 0; n < 6; n++) begin
            cycle(); checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL stall_drain cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (acc.size() - start != 2 || acc[start].typ != 1 || acc[start+1].typ != 2 || acc[start+1].key != 1) begin
            errors++; $display("FAIL stall_stream got n=%0d want press,release of key 1", acc.size() - start);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        waited = 0;
        iEventReady = 1'b0; iKey[3] = 1'b1;
        while (oEventValid !== 1'b1 && waited < 60) begin
            cycle(); waited++; checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL pre_reset cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (oEventValid !== 1'b1) begin
            errors++; $display("FAIL reset_mid_timeout got valid=%b want 1 within 60 clocks", oEventValid);
        end
        #2 iResetN = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 10'd0) begin
            errors++; $display("FAIL async_reset got=%b want=%b", obs_vec(), 10'd0);
        end
        model_reset();
        repeat (3) cycle();
        iResetN = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (n == 12) iEventReady = 1'b1;
            cycle(); checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL post_reset cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
            if (n < 8) begin
                checks++;
                if (oEventValid !== 1'b0) begin
                    errors++; $display("FAIL no_event_after_reset n=%0d got valid=%b want 0", n, oEventValid);
                end
            end
        end
        iKey = '0;
        repeat (40) cycle();
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                k = $urandom_range(0, NK - 1);
                iKey[k] = $urandom_range(0, 1);
            end
            iEventReady = ($urandom_range(0, 3) != 0);
            cycle(); checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_chatter();
        test_hold_repeat();
        test_back_to_back();
        test_stall_overwrite();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
